// File: rtl/backend_redirect_ctrl_if.sv
// rtl/backend_redirect_ctrl_if.sv - BackendRedirect handshake between commit stage and IF0
// Purpose : groups the redirect request/acknowledge signals.
// Signals : redirect, valid, redirectPC (initiator -> IF0), ready (IF0 -> initiator).
// Modports: master = commit-side initiator, slave = IF0 PC register.
interface backend_redirect_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              redirect;
    logic              valid;
    logic [ADDR_W-1:0] redirectPC;
    logic              ready;

    modport master (output redirect, output valid, output redirectPC, input ready);
    modport slave  (input redirect, input valid, input redirectPC, output ready);
endinterface

// File: rtl/backend_redirect_ctrl.sv
// rtl/backend_redirect_ctrl.sv - commit-stage redirect initiator with MIPS delay-slot ordering
// Purpose : watches both commit slots for mispredicts/exceptions, waits for a branch's
//           delay slot to commit, then holds a redirect toward IF0 until accepted.
// Ports   : clk, rst (async, active high); cm0_*/cm1_* commit slot info (slot 1 younger);
//           br (master modport: redirect/valid/redirectPC out, ready in);
//           flush (1-cycle pulse), commitStall, mispredCount/excCount statistics.
// Config  : REDIRECT_STATS_EN enables the statistics counters; otherwise they read 0.
module backend_redirect_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cm0_valid,
    input  logic                  cm0_mispred,
    input  logic [ADDR_W-1:0]     cm0_target,
    input  logic                  cm0_exc,
    input  logic [ADDR_W-1:0]     cm0_excPC,
    input  logic                  cm1_valid,
    input  logic                  cm1_mispred,
    input  logic [ADDR_W-1:0]     cm1_target,
    input  logic                  cm1_exc,
    input  logic [ADDR_W-1:0]     cm1_excPC,
    backend_redirect_ctrl_if.master br,
    output logic                  flush,
    output logic                  commitStall,
    output logic [31:0]           mispredCount,
    output logic [31:0]           excCount
);
    typedef enum logic [1:0] {IDLE, WAIT_DS, ISSUE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] tgt_q, tgt_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              redir_q, redir_n;
    logic              flush_q, flush_n;
    logic              stall_q, stall_n;

    // go: enter ISSUE next cycle with go_pc; go_exc marks an exception-caused redirect.
    logic              go;
    logic [ADDR_W-1:0] go_pc;
    logic              go_exc;
    logic              accept;

    assign accept = (state == ISSUE) && br.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tgt_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            redir_q <= 1'b0;
            flush_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_n;
            tgt_q   <= tgt_n;
            pc_q    <= pc_n;
            redir_q <= redir_n;
            flush_q <= flush_n;
            stall_q <= stall_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt_q;
        pc_n    = pc_q;
        redir_n = redir_q;
        flush_n = 1'b0;
        stall_n = stall_q;
        go      = 1'b0;
        go_pc   = tgt_q;
        go_exc  = 1'b0;
        case (state)
            IDLE: begin
                if (cm0_valid && cm0_exc) begin
                    go = 1'b1; go_pc = cm0_excPC; go_exc = 1'b1;
                end else if (cm0_valid && cm0_mispred && cm1_valid && cm1_exc) begin
                    // Delay slot faulted: the exception wins over the branch target.
                    go = 1'b1; go_pc = cm1_excPC; go_exc = 1'b1;
                end else if (cm0_valid && cm0_mispred && cm1_valid) begin
                    go = 1'b1; go_pc = cm0_target;
                end else if (cm0_valid && cm0_mispred) begin
                    tgt_n   = cm0_target;
                    state_n = WAIT_DS;
                end else if (cm1_valid && cm1_exc) begin
                    go = 1'b1; go_pc = cm1_excPC; go_exc = 1'b1;
                end else if (cm1_valid && cm1_mispred) begin
                    tgt_n   = cm1_target;
                    state_n = WAIT_DS;
                end
            end
            WAIT_DS: begin
                // The next retirement in slot 0 is the delay slot; slot 1 is flushed.
                if (cm0_valid) begin
                    go = 1'b1;
                    if (cm0_exc) begin
                        go_pc = cm0_excPC; go_exc = 1'b1;
                    end else begin
                        go_pc = tgt_q;
                    end
                end
            end
            ISSUE: begin
                if (br.ready) begin
                    state_n = IDLE;
                    redir_n = 1'b0;
                    stall_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (go) begin
            state_n = ISSUE;
            tgt_n   = go_pc;
            pc_n    = go_pc;
            redir_n = 1'b1;
            flush_n = 1'b1;
            stall_n = 1'b1;
        end
    end

    assign br.redirect   = redir_q;
    assign br.valid      = redir_q;
    assign br.redirectPC = pc_q;
    assign flush         = flush_q;
    assign commitStall   = stall_q;

`ifdef REDIRECT_STATS_EN
    logic        exc_q;
    logic [31:0] mis_cnt, exc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_q   <= 1'b0;
            mis_cnt <= 32'd0;
            exc_cnt <= 32'd0;
        end else begin
            if (go) exc_q <= go_exc;
            if (accept) begin
                if (exc_q) exc_cnt <= exc_cnt + 32'd1;
                else       mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

    assign mispredCount = mis_cnt;
    assign excCount     = exc_cnt;
`else
    logic unused_stats;
    assign unused_stats = go_exc ^ accept;
    assign mispredCount = 32'd0;
    assign excCount     = 32'd0;
`endif
endmodule

// File: tb/tb_backend_redirect_ctrl.sv
// tb/tb_backend_redirect_ctrl.sv - directed self-checking bench for backend_redirect_ctrl
module tb_backend_redirect_ctrl;
    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm0_valid, cm0_mispred, cm0_exc;
    logic [31:0] cm0_target, cm0_excPC;
    logic        cm1_valid, cm1_mispred, cm1_exc;
    logic [31:0] cm1_target, cm1_excPC;
    logic        flush, commitStall;
    logic [31:0] mispredCount, excCount;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_mis = 0;
    int exp_exc = 0;

    backend_redirect_ctrl_if #(.ADDR_W(32)) bif ();

    backend_redirect_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .cm0_valid(cm0_valid), .cm0_mispred(cm0_mispred), .cm0_target(cm0_target),
        .cm0_exc(cm0_exc), .cm0_excPC(cm0_excPC),
        .cm1_valid(cm1_valid), .cm1_mispred(cm1_mispred), .cm1_target(cm1_target),
        .cm1_exc(cm1_exc), .cm1_excPC(cm1_excPC),
        .br(bif.master),
        .flush(flush), .commitStall(commitStall),
        .mispredCount(mispredCount), .excCount(excCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cm0_valid = 0; cm0_mispred = 0; cm0_exc = 0; cm0_target = 0; cm0_excPC = 0;
        cm1_valid = 0; cm1_mispred = 0; cm1_exc = 0; cm1_target = 0; cm1_excPC = 0;
    endtask

    task automatic test_reset();
        rst = 1; bif.ready = 0; clear_inputs();
        #3;
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL reset_redirect got %b exp 0", bif.redirect); else pass_cnt++;
        total_cnt++; if (bif.valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bif.valid); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== RST_PC) $display("FAIL reset_pc got %h exp %h", bif.redirectPC, RST_PC); else pass_cnt++;
        total_cnt++; if ({flush, commitStall} !== 2'b00) $display("FAIL reset_flush_stall got %b exp 00", {flush, commitStall}); else pass_cnt++;
        tick(); tick();
        rst = 0;
        tick();
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL idle_redirect got %b exp 0", bif.redirect); else pass_cnt++;
    endtask

    task automatic test_mispred_pair();
        cm0_valid = 1; cm0_mispred = 1; cm0_target = 32'hbfc00100; cm1_valid = 1;
        tick(); clear_inputs();
        total_cnt++; if ({bif.redirect, bif.valid} !== 2'b11) $display("FAIL pair_req got %b exp 11", {bif.redirect, bif.valid}); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== 32'hbfc00100) $display("FAIL pair_pc got %h exp bfc00100", bif.redirectPC); else pass_cnt++;
        total_cnt++; if ({flush, commitStall} !== 2'b11) $display("FAIL pair_flush_stall got %b exp 11", {flush, commitStall}); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_mis++;
        total_cnt++; if ({bif.redirect, bif.valid, flush, commitStall} !== 4'b0000) $display("FAIL pair_done got %b exp 0000", {bif.redirect, bif.valid, flush, commitStall}); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== 32'hbfc00100) $display("FAIL pair_pc_keep got %h exp bfc00100", bif.redirectPC); else pass_cnt++;
    endtask

    task automatic test_wait_ds();
        cm1_valid = 1; cm1_mispred = 1; cm1_target = 32'h80001000;
        tick(); clear_inputs();
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL wait_ds_idle%0d got %b exp 0", i, bif.redirect); else pass_cnt++;
            if (i < 2) tick();
        end
        cm0_valid = 1;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirect !== 1'b1) $display("FAIL wait_ds_req got %b exp 1", bif.redirect); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== 32'h80001000) $display("FAIL wait_ds_pc got %h exp 80001000", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_mis++;
        // Slot-0 branch alone, then delay slot commits with a faulting slot 1 that must be ignored.
        cm0_valid = 1; cm0_mispred = 1; cm0_target = 32'h80002000;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL ds0_wait got %b exp 0", bif.redirect); else pass_cnt++;
        cm0_valid = 1; cm1_valid = 1; cm1_exc = 1; cm1_excPC = 32'hdeadbeef;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirectPC !== 32'h80002000) $display("FAIL ds0_pc got %h exp 80002000", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_mis++;
    endtask

    task automatic test_ds_exc();
        cm1_valid = 1; cm1_mispred = 1; cm1_target = 32'h80001000;
        tick(); clear_inputs();
        cm0_valid = 1; cm0_exc = 1; cm0_excPC = 32'hbfc00380;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirectPC !== 32'hbfc00380) $display("FAIL ds_exc_pc got %h exp bfc00380", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_exc++;
    endtask

    task automatic test_hold();
        cm0_valid = 1; cm0_exc = 1; cm0_excPC = 32'h80000180;
        tick(); clear_inputs();
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if ({bif.redirect, commitStall} !== 2'b11) $display("FAIL hold_req%0d got %b exp 11", i, {bif.redirect, commitStall}); else pass_cnt++;
            total_cnt++; if (bif.redirectPC !== 32'h80000180) $display("FAIL hold_pc%0d got %h exp 80000180", i, bif.redirectPC); else pass_cnt++;
            total_cnt++; if (flush !== (i == 0)) $display("FAIL hold_flush%0d got %b exp %b", i, flush, (i == 0)); else pass_cnt++;
            cm0_valid = 1; cm0_mispred = i[0]; cm0_exc = ~i[0]; cm0_excPC = 32'h1000 + i;
            cm0_target = 32'h2000 + i; cm1_valid = 1; cm1_exc = 1; cm1_excPC = 32'h3000 + i;
            tick();
        end
        clear_inputs();
        total_cnt++; if (bif.redirectPC !== 32'h80000180) $display("FAIL hold_pc_end got %h exp 80000180", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_exc++;
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL hold_done got %b exp 0", bif.redirect); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cm0_valid = 1; cm0_mispred = 1; cm0_target = 32'h11110000;
        cm1_valid = 1; cm1_exc = 1; cm1_excPC = 32'hbfc00380;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirectPC !== 32'hbfc00380) $display("FAIL b2b_ds_fault_pc got %h exp bfc00380", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_exc++;
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL b2b_gap got %b exp 0", bif.redirect); else pass_cnt++;
        cm1_valid = 1; cm1_exc = 1; cm1_excPC = 32'h80000200;
        tick(); clear_inputs();
        total_cnt++; if ({bif.redirect, flush} !== 2'b11) $display("FAIL b2b_req got %b exp 11", {bif.redirect, flush}); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== 32'h80000200) $display("FAIL b2b_pc got %h exp 80000200", bif.redirectPC); else pass_cnt++;
        bif.ready = 1; tick(); bif.ready = 0; exp_exc++;
    endtask

    task automatic test_stats();
        int em, ee;
`ifdef REDIRECT_STATS_EN
        em = exp_mis; ee = exp_exc;
`else
        em = 0; ee = 0;
`endif
        total_cnt++; if (mispredCount !== 32'(em)) $display("FAIL stats_mispred got %0d exp %0d", mispredCount, em); else pass_cnt++;
        total_cnt++; if (excCount !== 32'(ee)) $display("FAIL stats_exc got %0d exp %0d", excCount, ee); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        cm0_valid = 1; cm0_exc = 1; cm0_excPC = 32'h80000180;
        tick(); clear_inputs();
        total_cnt++; if (bif.redirect !== 1'b1) $display("FAIL arst_pre got %b exp 1", bif.redirect); else pass_cnt++;
        #2 rst = 1;
        #1;
        total_cnt++; if ({bif.redirect, bif.valid, flush, commitStall} !== 4'b0000) $display("FAIL arst_outs got %b exp 0000", {bif.redirect, bif.valid, flush, commitStall}); else pass_cnt++;
        total_cnt++; if (bif.redirectPC !== RST_PC) $display("FAIL arst_pc got %h exp %h", bif.redirectPC, RST_PC); else pass_cnt++;
        total_cnt++; if ({mispredCount, excCount} !== 64'd0) $display("FAIL arst_stats got %h exp 0", {mispredCount, excCount}); else pass_cnt++;
        tick(); rst = 0; tick();
        total_cnt++; if (bif.redirect !== 1'b0) $display("FAIL arst_after got %b exp 0", bif.redirect); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mispred_pair();
        test_wait_ds();
        test_ds_exc();
        test_hold();
        test_back_to_back();
        test_stats();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/backend_redirect_ctrl.md
Name: backend_redirect_ctrl

Overview:
- Initiator side of the BackendRedirect interface: produces redirect/valid/redirectPC toward the IF0 PC register and consumes its ready.
- Sits at the commit stage. Watches the two commit slots for branch mispredictions and exceptions.
- Enforces MIPS delay-slot ordering: a mispredict redirect is issued only after its delay slot commits.
- Holds the request until IF0 accepts it, and stalls commit while a redirect is outstanding.

Parameters:
- ADDR_W, 32, width of PC/target fields.
- RESET_PC, 32'hbfc00000, value driven on redirectPC while idle/after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cm0_valid  in  1  commit slot 0 retires an instruction this cycle
- cm0_mispred  in  1  slot 0 is a branch whose resolved direction/target differs from prediction
- cm0_target  in  ADDR_W  slot 0 correct branch target
- cm0_exc  in  1  slot 0 raises exception/eret
- cm0_excPC  in  ADDR_W  slot 0 exception vector or EPC for eret
- cm1_valid, cm1_mispred, cm1_target, cm1_exc, cm1_excPC  in  1/1/ADDR_W/1/ADDR_W  same for slot 1 (younger)
- ready  in  1  IF0 accepts redirect
- redirect  out  1  redirect request
- valid  out  1  request valid (always equal to redirect)
- redirectPC  out  ADDR_W  fetch restart address
- flush  out  1  one-cycle backend flush pulse
- commitStall  out  1  commit stage must retire nothing this cycle
- mispredCount, excCount  out  32  statistics (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE; redirect=0, valid=0, flush=0, commitStall=0, redirectPC=RESET_PC, pending target=RESET_PC.
- States:
  - IDLE: no request pending.
  - WAIT_DS: branch mispredict seen, delay slot not yet committed.
  - ISSUE: request presented to IF0.
- All outputs are registered. redirect/valid rise the cycle after the triggering commit, so latency is 1.
- IDLE decisions, evaluated each cycle in this priority order:
  1. cm0_valid & cm0_exc: target = cm0_excPC -> ISSUE. Slot 1 is ignored.
  2. cm0_valid & cm0_mispred & cm1_valid & cm1_exc: the delay slot faulted, so target = cm1_excPC -> ISSUE.
  3. cm0_valid & cm0_mispred & cm1_valid: the delay slot committed alongside, so target = cm0_target -> ISSUE.
  4. cm0_valid & cm0_mispred & !cm1_valid: latch cm0_target -> WAIT_DS.
  5. cm1_valid & cm1_exc: target = cm1_excPC -> ISSUE.
  6. cm1_valid & cm1_mispred: latch cm1_target -> WAIT_DS.
  7. Otherwise stay IDLE.
- WAIT_DS:
  - Holds until cm0_valid.
  - On cm0_valid: cm0_exc gives target = cm0_excPC; otherwise target = latched branch target. Go to ISSUE.
  - Slot 1 content in that cycle is ignored; the backend flush discards it.
- ISSUE:
  - redirect=valid=1; redirectPC holds target stable; commitStall=1.
  - flush=1 only in the first ISSUE cycle.
  - On a posedge with ready=1: go to IDLE, redirect/valid drop next cycle, redirectPC keeps its last value.
  - Commit inputs are ignored while in ISSUE.
- Back-to-back: in the IDLE cycle right after ISSUE, a new event is accepted normally.
- Reset mid-ISSUE or mid-WAIT_DS discards the pending target immediately (asynchronous).

Optional Feature:
- Macro REDIRECT_STATS_EN.
- Defined:
  - mispredCount increments by 1 on each ISSUE acceptance (ready=1) caused by a mispredict.
  - excCount increments on each accepted exception redirect.
  - Both reset to 0 and wrap 32'hffffffff -> 0.
- Undefined: both outputs tied to 0 and no counter flops are generated.

Test Plan:
- Reset, then cm0_valid=1, cm0_mispred=1, cm0_target=32'hbfc00100, cm1_valid=1 -> next cycle redirect=valid=1, redirectPC=32'hbfc00100, flush pulses 1 cycle; ready=1 -> IDLE next cycle.
- cm1_mispred=1 with cm1_target=32'h80001000; 3 idle cycles; then cm0_valid=1 -> no redirect during the 3 cycles; redirect with PC 32'h80001000 one cycle after the delay slot commits.
- In WAIT_DS (target 32'h80001000), delay slot commits with cm0_exc=1, cm0_excPC=32'hbfc00380 -> redirectPC=32'hbfc00380, not 32'h80001000.
- ISSUE held with ready=0 for 4 cycles while commit inputs toggle -> redirectPC stable, commitStall=1 throughout, flush high only in the first cycle.
- Assert rst asynchronously mid-ISSUE -> redirect/valid fall without a clock edge, redirectPC=32'hbfc00000; with REDIRECT_STATS_EN, one accepted mispredict plus one accepted exception -> mispredCount=1, excCount=1.
